// File: rtl/instruction_decoder_if.sv
// Command-side and memory-side signal bundle for instruction_decoder.
// slave = the decoder, master = host plus memory controller.
interface instruction_decoder_if;
    logic        instr_valid;
    logic [27:0] instruction;
    logic        instr_ready;
    logic        mem_done;
    logic        enable;
    logic [2:0]  operation;
    logic [16:0] addr_base;
    logic [7:0]  wr_data;
    logic [2:0]  current_zoom;
    logic        busy;
    logic        error;

    modport slave (
        input  instr_valid, instruction, mem_done,
        output instr_ready, enable, operation, addr_base, wr_data, current_zoom, busy, error
    );

    modport master (
        output instr_valid, instruction, mem_done,
        input  instr_ready, enable, operation, addr_base, wr_data, current_zoom, busy, error
    );
endinterface

// File: rtl/instruction_decoder.sv
// Host command decoder: queues commands, tracks the zoom level and runs one memory operation at a time.
// Define CMD_FIFO_EN for a 4-entry command FIFO; otherwise a single holding register is used.
module instruction_decoder (
    input  logic                 clock,
    input  logic                 reset_n,
    instruction_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_ZOOM_RESET = 3'b111;
    localparam logic [2:0] ZOOM_MIN      = 3'd0;
    localparam logic [2:0] ZOOM_MAX      = 3'd4;
    localparam logic [2:0] ZOOM_DEFAULT  = 3'd2;
    localparam logic [1:0] ACK_LAST      = 2'd3;

    function automatic logic is_zoom_in(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100);
    endfunction

    function automatic logic is_zoom_out(input logic [2:0] op);
        return (op == 3'b101) || (op == 3'b110);
    endfunction

    function automatic logic zoom_illegal(input logic [2:0] op, input logic [2:0] zoom);
        return (is_zoom_in(op) && (zoom >= ZOOM_MAX)) || (is_zoom_out(op) && (zoom == ZOOM_MIN));
    endfunction

    state_t      state_r;
    logic        armed_r;
    logic [2:0]  operation_r;
    logic [16:0] addr_base_r;
    logic [7:0]  wr_data_r;
    logic [2:0]  zoom_r;
    logic        error_r;
    logic        enable_r;
    logic [1:0]  ack_cnt_r;

    logic [27:0] head_s;
    logic        q_empty_s;
    logic        ready_s;
    logic        accept_s;
    logic        pop_s;
    logic        error_event_s;

    assign accept_s = bus.instr_valid && ready_s;
    assign pop_s    = (state_r == ST_IDLE) && !q_empty_s;

`ifdef CMD_FIFO_EN
    logic [3:0][27:0] fifo_mem_r;
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [2:0]       count_r;

    assign head_s    = fifo_mem_r[rd_ptr_r];
    assign q_empty_s = (count_r == 3'd0);
    assign ready_s   = armed_r && (count_r < 3'd4);

    // Command FIFO; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem_r <= {112{1'b0}};
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            count_r    <= 3'd0;
        end else begin
            if (accept_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.instruction;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end
`else
    logic [27:0] hold_r;
    logic        hold_valid_r;

    assign head_s    = hold_r;
    assign q_empty_s = !hold_valid_r;
    assign ready_s   = armed_r && (state_r == ST_IDLE) && !hold_valid_r;

    // Single-entry holding register; accept and pop can never coincide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_r       <= 28'd0;
            hold_valid_r <= 1'b0;
        end else if (accept_s) begin
            hold_r       <= bus.instruction;
            hold_valid_r <= 1'b1;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end
`endif

    // Error sources: illegal zoom at decode, or mem_done never falling during the ack window
    always_comb begin
        error_event_s = 1'b0;
        if ((state_r == ST_CHECK) && zoom_illegal(operation_r, zoom_r)) begin
            error_event_s = 1'b1;
        end else if ((state_r == ST_WAIT_ACK) && bus.mem_done && (ack_cnt_r == ACK_LAST)) begin
            error_event_s = 1'b1;
        end else begin
            error_event_s = 1'b0;
        end
    end

    // Sequencer and registered outputs; zoom moves only once the memory operation completes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b0;
            operation_r <= 3'b000;
            addr_base_r <= 17'd0;
            wr_data_r   <= 8'd0;
            zoom_r      <= ZOOM_DEFAULT;
            error_r     <= 1'b0;
            enable_r    <= 1'b0;
            ack_cnt_r   <= 2'd0;
        end else begin
            armed_r  <= 1'b1;
            enable_r <= 1'b0;
            if (error_event_s) begin
                error_r <= 1'b1;
            end else if (accept_s) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        operation_r <= head_s[2:0];
                        addr_base_r <= head_s[19:3];
                        wr_data_r   <= head_s[27:20];
                        state_r     <= ST_CHECK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (operation_r == OP_ZOOM_RESET) begin
                        zoom_r  <= ZOOM_DEFAULT;
                        state_r <= ST_IDLE;
                    end else if ((operation_r == OP_NOP) || zoom_illegal(operation_r, zoom_r)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        enable_r <= 1'b1;
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ack_cnt_r <= 2'd0;
                    state_r   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!bus.mem_done) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (ack_cnt_r == ACK_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.mem_done) begin
                        state_r <= ST_IDLE;
                        if (is_zoom_in(operation_r)) begin
                            zoom_r <= zoom_r + 3'd1;
                        end else if (is_zoom_out(operation_r)) begin
                            zoom_r <= zoom_r - 3'd1;
                        end else begin
                            zoom_r <= zoom_r;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready  = ready_s;
    assign bus.enable       = enable_r;
    assign bus.operation    = operation_r;
    assign bus.addr_base    = addr_base_r;
    assign bus.wr_data      = wr_data_r;
    assign bus.current_zoom = zoom_r;
    assign bus.error        = error_r;
    assign bus.busy         = (state_r != ST_IDLE) || !q_empty_s;
endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed scenarios plus random commands against a transaction-level model.
// Builds with or without CMD_FIFO_EN.
module tb_instruction_decoder;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    bit   mem_stuck;

    // Model state: zoom level, expected error after the last command, expected issue records
    int          m_zoom;
    bit          m_err;
    logic [30:0] exp_q[$];
    logic [30:0] got_q[$];

    instruction_decoder_if dif ();

    instruction_decoder dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory controller model: drops mem_done one cycle after enable, raises it 3 cycles later
    initial begin
        dif.mem_done = 1'b1;
        forever begin
            @(negedge clk);
            if (dif.enable && !mem_stuck) begin
                @(posedge clk);
                #1 dif.mem_done = 1'b0;
                repeat (3) @(posedge clk);
                #1 dif.mem_done = 1'b1;
            end
        end
    end

    // Issue monitor: every enable pulse is one cycle wide and is recorded with the forwarded fields
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.enable) begin
                check("enable_single_cycle", {31'd0, prev_en}, 32'd0);
                got_q.push_back({dif.operation, dif.addr_base, dif.wr_data, dif.current_zoom});
            end
            prev_en = dif.enable;
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] data,
                            output time t_acc);
        int n;
        logic ok;
        ok = 1'b0;
        t_acc = 0;
        @(negedge clk);
        dif.instruction = {data, addr, op};
        dif.instr_valid = 1'b1;
        n = 0;
        while (!dif.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (dif.instr_ready) begin
            @(posedge clk);
            t_acc = $time;
            ok = 1'b1;
            #1;
        end
        dif.instr_valid = 1'b0;
        check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] data);
        bit issue;
        int next_zoom;
        issue = 1'b0;
        next_zoom = m_zoom;
        m_err = 1'b0;
        case (op)
            3'b000: ;
            3'b111: next_zoom = 2;
            3'b001, 3'b010: issue = 1'b1;
            3'b011, 3'b100: if (m_zoom < 4) begin issue = 1'b1; next_zoom = m_zoom + 1; end else m_err = 1'b1;
            default: if (m_zoom > 0) begin issue = 1'b1; next_zoom = m_zoom - 1; end else m_err = 1'b1;
        endcase
        if (issue) exp_q.push_back({op, addr, data, 3'(m_zoom)});
        if (issue && mem_stuck) m_err = 1'b1;
        else m_zoom = next_zoom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (dif.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, dif.busy}, 32'd0);
    endtask

    task automatic compare_issues();
        logic [30:0] g;
        logic [30:0] e;
        check("issue_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("issue_fields", {1'b0, g}, {1'b0, e});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_cmd();
        wait_idle();
        check("error_flag", {31'd0, dif.error}, {31'd0, m_err});
        check("current_zoom", {29'd0, dif.current_zoom}, m_zoom);
        compare_issues();
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] data);
        time t;
        send_cmd(op, addr, data, t);
        model_apply(op, addr, data);
        finish_cmd();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"},    {31'd0, dif.enable},       32'd0);
        check({tag, "_operation"}, {29'd0, dif.operation},    32'd0);
        check({tag, "_addr_base"}, {15'd0, dif.addr_base},    32'd0);
        check({tag, "_wr_data"},   {24'd0, dif.wr_data},      32'd0);
        check({tag, "_zoom"},      {29'd0, dif.current_zoom}, 32'd2);
        check({tag, "_error"},     {31'd0, dif.error},        32'd0);
        check({tag, "_busy"},      {31'd0, dif.busy},         32'd0);
        check({tag, "_ready"},     {31'd0, dif.instr_ready},  32'd0);
    endtask

    initial begin
        time t_a;
        time t_b;
        int  fall_k;
        logic [2:0]  r_op;
        logic [16:0] r_addr;
        logic [7:0]  r_data;

        vectors = 0;
        miscompares = 0;
        mem_stuck = 1'b0;
        m_zoom = 2;
        m_err = 1'b0;
        reset_n = 1'b0;
        dif.instr_valid = 1'b0;
        dif.instruction = 28'd0;

        // Reset values, then ready rises on the first edge after release
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, dif.instr_ready}, 32'd0);
        @(posedge clk);
        #1 check("ready_after_first_edge", {31'd0, dif.instr_ready}, 32'd1);

        // WR: enable at N+2, fields stable, busy falls only after mem_done rises
        send_cmd(3'b010, 17'h00123, 8'hA5, t_a);
        model_apply(3'b010, 17'h00123, 8'hA5);
        fall_k = -1;
        for (int k = 0; k < 20 && fall_k < 0; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 3) check("wr_enable_timing", {31'd0, dif.enable}, (k == 2) ? 32'd1 : 32'd0);
            if (!dif.busy) begin
                fall_k = k;
                check("wr_busy_fall_mem_done", {31'd0, dif.mem_done}, 32'd1);
            end else if (k >= 1) begin
                check("wr_operation", {29'd0, dif.operation}, 32'h2);
                check("wr_addr_base", {15'd0, dif.addr_base}, 32'h00123);
                check("wr_data",      {24'd0, dif.wr_data},   32'hA5);
            end
        end
        check("wr_busy_fall_cycle", fall_k, 32'd7);
        finish_cmd();

        // Three NHI from zoom 2: 3, 4, then illegal
        do_cmd(3'b011, 17'h00010, 8'h01);
        do_cmd(3'b011, 17'h00020, 8'h02);
        do_cmd(3'b011, 17'h00030, 8'h03);
        check("nhi_third_error", {31'd0, dif.error}, 32'd1);
        check("nhi_third_zoom", {29'd0, dif.current_zoom}, 32'd4);

        // Walk down to zoom 0, illegal BA, then ZOOM_RESET clears error at its accept edge
        do_cmd(3'b111, 17'h00000, 8'h00);
        do_cmd(3'b101, 17'h00040, 8'h04);
        do_cmd(3'b110, 17'h00050, 8'h05);
        do_cmd(3'b110, 17'h00060, 8'h06);
        check("ba_at_zero_error", {31'd0, dif.error}, 32'd1);
        send_cmd(3'b111, 17'h00000, 8'h00, t_a);
        check("error_clear_on_accept", {31'd0, dif.error}, 32'd0);
        model_apply(3'b111, 17'h00000, 8'h00);
        finish_cmd();
        check("zoom_after_reset_cmd", {29'd0, dif.current_zoom}, 32'd2);

        // mem_done stuck high: error after 4 WAIT_ACK cycles, single enable pulse
        mem_stuck = 1'b1;
        send_cmd(3'b001, 17'h0ABCD, 8'h00, t_a);
        model_apply(3'b001, 17'h0ABCD, 8'h00);
        repeat (7) @(negedge clk);
        check("stuck_error_before", {31'd0, dif.error}, 32'd0);
        check("stuck_busy_before", {31'd0, dif.busy}, 32'd1);
        @(negedge clk);
        check("stuck_error_set", {31'd0, dif.error}, 32'd1);
        check("stuck_back_idle", {31'd0, dif.busy}, 32'd0);
        repeat (10) @(negedge clk);
        finish_cmd();
        mem_stuck = 1'b0;

`ifdef CMD_FIFO_EN
        // Four commands queue behind a running one; a fifth is refused and never issues
        send_cmd(3'b001, 17'h00100, 8'h10, t_a);
        model_apply(3'b001, 17'h00100, 8'h10);
        for (int i = 1; i < 5; i++) begin
            r_op = (i % 2 == 1) ? 3'b010 : 3'b001;
            r_addr = 17'h00100 + 17'(i);
            r_data = 8'h10 + 8'(i);
            send_cmd(r_op, r_addr, r_data, t_b);
            model_apply(r_op, r_addr, r_data);
        end
        @(negedge clk);
        dif.instruction = {8'hFF, 17'h1FFFF, 3'b001};
        dif.instr_valid = 1'b1;
        check("fifo_full_ready_low", {31'd0, dif.instr_ready}, 32'd0);
        @(posedge clk);
        #1 dif.instr_valid = 1'b0;
        check("fifo_full_still_low", {31'd0, dif.instr_ready}, 32'd0);
        finish_cmd();
`else
        // Holding register: the second command waits until the first has returned to IDLE
        send_cmd(3'b001, 17'h00100, 8'h10, t_a);
        model_apply(3'b001, 17'h00100, 8'h10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_ready_low", {31'd0, dif.instr_ready}, 32'd0);
        end
        send_cmd(3'b010, 17'h00101, 8'h11, t_b);
        model_apply(3'b010, 17'h00101, 8'h11);
        check("hold_second_accept_delay", int'(t_b - t_a), 32'd80);
        finish_cmd();
`endif

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_addr = 17'($urandom);
            r_data = 8'($urandom);
            do_cmd(r_op, r_addr, r_data);
        end

        // Reset during WAIT_DONE of a PR at zoom 3
        do_cmd(3'b111, 17'h00000, 8'h00);
        do_cmd(3'b011, 17'h00200, 8'h20);
        send_cmd(3'b100, 17'h00300, 8'h30, t_a);
        model_apply(3'b100, 17'h00300, 8'h30);
        repeat (5) @(negedge clk);
        check("pr_in_wait_done_busy", {31'd0, dif.busy}, 32'd1);
        check("pr_in_wait_done_mem", {31'd0, dif.mem_done}, 32'd0);
        reset_n = 1'b0;
        #1 check_reset_outputs("mid_op");
        m_zoom = 2;
        m_err = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_mid_reset", {31'd0, dif.instr_ready}, 32'd1);
        repeat (10) @(negedge clk);
        check("no_enable_after_reset_zoom", {29'd0, dif.current_zoom}, 32'd2);
        compare_issues();
        do_cmd(3'b011, 17'h00400, 8'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
